// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - saturating batch accumulator for the adder's 5-bit sum stream
// Collects up to N sums per batch and holds the total/count/overflow until taken downstream.
module sum_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 6,
  localparam int CW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       in_sum,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_total,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf,
  input  logic             out_ready
);

  typedef enum logic {ACC, OUT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [ACC_W-1:0] r_out_total;
  logic [CW-1:0]    r_out_count;
  logic             r_out_ovf;
  logic             w_accept;
  logic             w_close;
  logic [ACC_W:0]   w_sum;

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == OUT);
  assign out_total = r_out_total;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_accept = in_valid & in_ready;
  // One extra bit catches overflow of a single add; the sticky flag covers the rest of the batch.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W - 4){1'b0}}, in_sum};

  always_comb begin
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_state_nxt = r_state;
    w_close     = 1'b0;
    if (w_accept) begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (r_ovf || w_sum[ACC_W]) begin
        w_acc_nxt = '1;
        w_ovf_nxt = 1'b1;
      end else begin
        w_acc_nxt = w_sum[ACC_W-1:0];
      end
    end
    case (r_state)
      ACC: begin
        w_close = (w_accept && (w_cnt_nxt == CW'(N))) || (flush && (w_cnt_nxt != '0));
        if (w_close) w_state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) w_state_nxt = ACC;
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_total <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_close) begin
      r_out_total <= w_acc_nxt;
      r_out_count <= w_cnt_nxt;
      r_out_ovf   <= w_ovf_nxt;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard bench for sum_accumulator (N=4, ACC_W=6)
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [4:0] in_sum;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [5:0] out_total;
  logic [2:0] out_count;
  logic       out_ovf;
  logic       out_ready;

  always #5 clk = ~clk;

  sum_accumulator #(.N(4), .ACC_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_total (out_total),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [5:0] total;
    logic [2:0] count;
    logic       ovf;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  int   m_acc = 0;
  int   m_cnt = 0;
  bit   m_ovf = 1'b0;
  bit   m_out = 1'b0;
  bit   use_model = 1'b0;
  int   accepted = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_res(input int total, input int count, input bit ovf);
    res_t r;
    r.total = 6'(total);
    r.count = 3'(count);
    r.ovf   = ovf;
    exp_q.push_back(r);
  endtask

  // Monitor: peeks while result is held (stability under backpressure), pops on handshake.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("out_total", int'(out_total), int'(exp_q[0].total));
        chk("out_count", int'(out_count), int'(exp_q[0].count));
        chk("out_ovf", int'(out_ovf), int'(exp_q[0].ovf));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drives one cycle (called just after a rising edge), checks handshake outputs, advances the model.
  task automatic step(input bit v, input logic [4:0] s, input bit f, input bit r);
    int nx;
    in_valid  = v;
    in_sum    = s;
    flush     = f;
    out_ready = r;
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(!m_out));
    chk("out_valid", int'(out_valid), int'(m_out));
    if (m_out) begin
      if (r) m_out = 1'b0;
    end else begin
      if (v) begin
        accepted++;
        nx = m_acc + int'(s);
        if (nx > 63 || m_ovf) begin
          m_acc = 63;
          m_ovf = 1'b1;
        end else begin
          m_acc = nx;
        end
        m_cnt++;
      end
      if ((v && m_cnt == 4) || (f && m_cnt >= 1)) begin
        if (use_model) expect_res(m_acc, m_cnt, m_ovf);
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_out = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_total", int'(out_total), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    expect_res(24, 4, 1'b0);
    step(1, 3, 0, 1); step(1, 5, 0, 1); step(1, 7, 0, 1); step(1, 9, 0, 1);
    step(0, 0, 0, 1);

    expect_res(63, 4, 1'b1);
    step(1, 31, 0, 1); step(1, 31, 0, 1); step(1, 31, 0, 1); step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    expect_res(4, 4, 1'b0);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    step(0, 0, 0, 1);

    expect_res(22, 2, 1'b0);
    step(1, 10, 0, 1); step(1, 12, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);

    expect_res(8, 4, 1'b0);
    expect_res(12, 4, 1'b0);
    step(1, 2, 0, 0); step(1, 2, 0, 0); step(1, 2, 0, 0); step(1, 2, 0, 0);
    repeat (5) step(1, 9, 0, 0);
    step(1, 9, 0, 1);
    step(1, 9, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    step(0, 0, 0, 1);

    step(1, 4, 0, 1); step(1, 4, 0, 1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_total", int'(out_total), 0);
    chk("mid_rst_out_count", int'(out_count), 0);
    chk("mid_rst_out_ovf", int'(out_ovf), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    #1 reset = 1'b1;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_out = 1'b0;
    @(posedge clk);
    #1;
    expect_res(10, 4, 1'b0);
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1); step(1, 4, 0, 1);
    step(0, 0, 0, 1);

    use_model = 1'b1;
    accepted  = 0;
    for (int c = 0; c < 5000 && accepted < 200; c++) begin
      step(bit'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
           bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 9) < 7));
    end
    chk("random_accepted", accepted, 200);
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
